pwm_out: RTL and testbench

Output stage of the synthesizer datapath. It takes the sign-magnitude sine sample from the wave generator and the SPI-supplied volume, and scales the magnitude by volume with a sequential shift-add multiplier. It converts the result to offset-binary duty and drives the 1-bit `carrier` pin as 8-bit PWM at clk/256 (156.25 kHz at 40 MHz). It replaces the combinational volume multiply and the unimplemented carrier logic in the top level.

---
 rtl/pwm_out.sv | 177 +++++++++++++++++
 tb/tb_pwm_out.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_out.sv
// pwm_out -- synthesizer output stage.
//
// Scales a sign-magnitude sine sample by a volume with an 8-cycle shift-add
// multiplier. The scaled magnitude is turned into an offset-binary duty
// (128 = silence). That duty drives an 8-bit PWM carrier at clk/256.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   sampleEn   one-cycle strobe per new sample; latches the operands and
//              starts the multiplier
//   sign       sample sign, 1 = negative
//   amplitude  sample magnitude, unsigned 8b
//   volume     target volume, unsigned 8b (0 = silent)
//   carrier    registered PWM output; high for exactly `duty` cycles per frame
//   duty       duty currently applied to the carrier (loaded at frame end)
//   busy       high while the multiplier is in MUL or DONE
//
// Build option:
//   PWM_VOL_RAMP_EN  When defined, the volume operand steps by +-1 toward
//                    `volume` on every strobe, which gives a click-free ramp.
//                    When undefined, the operand is loaded directly from
//                    `volume`.

module pwm_out (
  input  logic       clk,
  input  logic       reset,
  input  logic       sampleEn,
  input  logic       sign,
  input  logic [7:0] amplitude,
  input  logic [7:0] volume,
  output logic       carrier,
  output logic [7:0] duty,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [7:0]  pwm_count_reg;
  logic [7:0]  duty_reg;
  logic [7:0]  duty_next_reg;
  logic        carrier_reg;

  logic [7:0]  cur_vol_reg;
  logic [7:0]  amp_reg;
  logic        sign_reg;
  logic [2:0]  mul_count_reg;
  logic [15:0] acc_reg;

  logic [7:0]  vol_latch;
  logic [7:0]  half;
  logic [7:0]  duty_calc;
  logic        load_result;

  // ---------------------------------------------------------------------------
  // Volume operand captured on each strobe.
  // ---------------------------------------------------------------------------
`ifdef PWM_VOL_RAMP_EN
  always_comb begin
    vol_latch = cur_vol_reg;
    if (cur_vol_reg < volume) begin
      vol_latch = cur_vol_reg + 8'd1;
    end else if (cur_vol_reg > volume) begin
      vol_latch = cur_vol_reg - 8'd1;
    end
  end
`else
  assign vol_latch = volume;
`endif

  // ---------------------------------------------------------------------------
  // Shift-add partial products: addend[k] is (amplitude << k) when volume bit
  // k is set. The MUL state adds one of them per cycle, LSB first.
  // ---------------------------------------------------------------------------
  logic [15:0] addend [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_addend
    assign addend[gi] = cur_vol_reg[gi] ? ({8'd0, amp_reg} << gi) : 16'd0;
  end

  // ---------------------------------------------------------------------------
  // Result conversion.
  // half = (acc >> 8) >> 1, which is taken directly from acc[15:9].
  // The maximum half is 127, so 128 +- half stays within 1..255 and never
  // wraps.
  // ---------------------------------------------------------------------------
  assign half      = {1'b0, acc_reg[15:9]};
  assign duty_calc = sign_reg ? (8'd128 - half) : (8'd128 + half);

  // A strobe that arrives during DONE restarts the multiplier. It also drops
  // the result that would otherwise have been written in that cycle.
  assign load_result = (state_reg == DONE) && !sampleEn;

  // ---------------------------------------------------------------------------
  // Multiplier FSM: next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (sampleEn) begin
          state_next = MUL;
        end
      end
      MUL: begin
        if (sampleEn) begin
          state_next = MUL;
        end else if (mul_count_reg == 3'd7) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = sampleEn ? MUL : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      pwm_count_reg <= 8'd0;
      duty_reg      <= 8'd128;
      duty_next_reg <= 8'd128;
      carrier_reg   <= 1'b0;
      cur_vol_reg   <= 8'd0;
      amp_reg       <= 8'd0;
      sign_reg      <= 1'b0;
      mul_count_reg <= 3'd0;
      acc_reg       <= 16'd0;
    end else begin
      state_reg <= state_next;

      // Operand latch and multiplier datapath. A strobe always wins, so
      // the multiplier restarts from bit 0 even in the middle of a run.
      if (sampleEn) begin
        sign_reg      <= sign;
        amp_reg       <= amplitude;
        cur_vol_reg   <= vol_latch;
        acc_reg       <= 16'd0;
        mul_count_reg <= 3'd0;
      end else if (state_reg == MUL) begin
        acc_reg       <= acc_reg + addend[mul_count_reg];
        mul_count_reg <= mul_count_reg + 3'd1;
      end

      if (load_result) begin
        duty_next_reg <= duty_calc;
      end

      // PWM frame. The duty is swapped only on the last count of a frame,
      // so a frame never mixes two duty values.
      pwm_count_reg <= pwm_count_reg + 8'd1;
      if (pwm_count_reg == 8'd255) begin
        duty_reg <= duty_next_reg;
      end
      carrier_reg <= (pwm_count_reg < duty_reg);
    end
  end

  assign carrier = carrier_reg;
  assign duty    = duty_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_pwm_out.sv
// tb_pwm_out -- self-checking bench for pwm_out.
//
// A free-running reference counter mirrors the PWM frame position, which
// lets stimulus be placed at chosen points in a frame. The expected duty of
// each frame is queued when the stimulus is driven. A monitor pops one entry
// at each frame boundary. It compares the entry with `duty` and with the
// number of carrier-high cycles in that frame.

module tb_pwm_out;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sampleEn = 1'b0;
  logic       sign = 1'b0;
  logic [7:0] amplitude = 8'd0;
  logic [7:0] volume = 8'd0;
  logic       carrier;
  logic [7:0] duty;
  logic       busy;

  pwm_out dut (
    .clk       (clk),
    .reset     (reset),
    .sampleEn  (sampleEn),
    .sign      (sign),
    .amplitude (amplitude),
    .volume    (volume),
    .carrier   (carrier),
    .duty      (duty),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   last_exp = 128;
  int   model_vol = 0;
  logic meas_valid = 1'b0;
  int   frame_exp = 0;
  int   highs = 0;
  logic [7:0] model_cnt = 8'd0;

  // Reference frame position: 0 in the first cycle after reset.
  always @(posedge clk) begin
    model_cnt <= reset ? 8'd0 : model_cnt + 8'd1;
  end

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_duty(input int sgn, input int amp, input int vol);
    int scaled;
    int h;
    scaled = (amp * vol) / 256;
    h      = scaled / 2;
    return (sgn != 0) ? (128 - h) : (128 + h);
  endfunction

  // Volume operand the design should latch on a strobe.
  function automatic int strobe_vol(input int cur, input int tgt);
`ifdef PWM_VOL_RAMP_EN
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
`else
    return tgt + 0 * cur;
`endif
  endfunction

  // Monitor: one duty check per boundary and one high-time check per frame.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        meas_valid = 1'b0;
        highs = 0;
      end else begin
        if (carrier === 1'b1) highs++;
        if (model_cnt == 8'd0) begin
          if (meas_valid) check_value("frame_high", highs, frame_exp);
          highs = 0;
          meas_valid = 1'b0;
          if (exp_q.size() > 0) begin
            frame_exp = exp_q.pop_front();
            check_value("duty", {24'd0, duty}, frame_exp);
            $display("frame boundary: duty=%0d expected=%0d", duty, frame_exp);
            meas_valid = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_cnt(input int target);
    int n = 0;
    while (model_cnt != target[7:0] && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check_value("align", {24'd0, model_cnt}, target);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || meas_valid) && n < 1500) begin
      step();
      n++;
    end
    if (n >= 1500) check_value("drain_timeout", n, 0);
  endtask

  task automatic count_busy(input int expected);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check_value("busy_len", n, expected);
  endtask

  // Drive one strobe at frame position at_cnt. Optionally queue its result.
  task automatic send(input int sgn, input int amp, input int vol,
                      input int at_cnt, input bit push);
    int e;
    wait_cnt(at_cnt);
    model_vol = strobe_vol(model_vol, vol);
    e = exp_duty(sgn, amp, model_vol);
    if (push) begin
      exp_q.push_back(e);
      last_exp = e;
    end
    $display("sample: sign=%0d amp=%0d vol=%0d at cnt=%0d -> expect duty %0d",
             sgn, amp, vol, at_cnt, e);
    sign      = sgn[0];
    amplitude = amp[7:0];
    volume    = vol[7:0];
    sampleEn  = 1'b1;
    step();
    sampleEn  = 1'b0;
    if (push) count_busy(9);
  endtask

  initial begin
    int e;

    // Reset with no stimulus.
    reset = 1'b1;
    repeat (3) begin
      step();
      check_value("rst_carrier", {31'd0, carrier}, 0);
    end
    reset = 1'b0;
    step();
    check_value("rst_duty", {24'd0, duty}, 128);
    check_value("rst_busy", {31'd0, busy}, 0);
    exp_q.push_back(128);
    drain();

    // Positive full scale and negative half scale.
    send(0, 255, 255, 10, 1'b1);
    drain();
    send(1, 200, 128, 10, 1'b1);
    drain();

    // Back-to-back strobes. The stale result would reach the boundary at
    // T+11, so that boundary must still show the old duty.
    wait_cnt(244);
    exp_q.push_back(last_exp);
    model_vol = strobe_vol(model_vol, 255);
    sign = 1'b1; amplitude = 8'd50; volume = 8'd255; sampleEn = 1'b1;
    step();
    sampleEn = 1'b0;
    repeat (3) step();
    check_value("b2b_busy", {31'd0, busy}, 1);
    model_vol = strobe_vol(model_vol, 255);
    e = exp_duty(0, 100, model_vol);
    exp_q.push_back(e);
    last_exp = e;
    $display("sample: back-to-back restart amp=100 vol=255 -> expect duty %0d", e);
    sign = 1'b0; amplitude = 8'd100; sampleEn = 1'b1;
    step();
    sampleEn = 1'b0;
    count_busy(9);
    drain();

    // DONE lands on the cycle where the frame counter reads 255.
    exp_q.push_back(last_exp);
    send(1, 255, 255, 246, 1'b1);
    drain();

    // Zero-magnitude and zero-volume samples.
    send(0, 0, 200, 10, 1'b1);
    drain();
    send(0, 100, 200, 10, 1'b1);
    drain();
    send(1, 180, 0, 10, 1'b1);
    drain();

    // Volume step 0 -> 4 from a clean reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_vol = 0;
    last_exp = 128;
    for (int i = 0; i < 5; i++) begin
      send(0, 255, 4, 10, 1'b1);
      drain();
    end

    // Reset in the middle of a multiply.
    send(1, 255, 255, 10, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    step();
    check_value("midrst_duty", {24'd0, duty}, 128);
    check_value("midrst_busy", {31'd0, busy}, 0);
    check_value("midrst_carrier", {31'd0, carrier}, 0);
    reset = 1'b0;
    model_vol = 0;
    last_exp = 128;
    exp_q.push_back(128);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
